// File: rtl/intersection_ctrl.sv
// Two-way intersection sequencer: NS/EW heads, all-red clearance and
// a latched pedestrian WALK phase, all timed from one down-counter.
module intersection_ctrl #(
    parameter int CNT_W      = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       hold,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5,
        WALK = 3'd6
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] timer;
    logic             adv;

    function automatic logic [CNT_W-1:0] load(input state_t s);
        case (s)
            NS_G, EW_G: load = CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y: load = CNT_W'(YELLOW_CYC - 1);
            WALK:       load = CNT_W'(WALK_CYC - 1);
            default:    load = CNT_W'(ALLRED_CYC - 1);
        endcase
    endfunction

    function automatic state_t succ(input state_t s, input logic pend);
        case (s)
            NS_G:    succ = NS_Y;
            NS_Y:    succ = AR_A;
            AR_A:    succ = EW_G;
            EW_G:    succ = EW_Y;
            EW_Y:    succ = AR_B;
            AR_B:    succ = pend ? WALK : NS_G;
            WALK:    succ = NS_G;
            default: succ = AR_B;
        endcase
    endfunction

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    function automatic logic [6:0] lamps(input state_t s);
        case (s)
            NS_G:    lamps = 7'b0011000;
            NS_Y:    lamps = 7'b0101000;
            EW_G:    lamps = 7'b1000010;
            EW_Y:    lamps = 7'b1000100;
            WALK:    lamps = 7'b1001001;
            default: lamps = 7'b1001000;
        endcase
    endfunction

    assign adv = (timer == '0) && !hold;

    // Encoding 7 is not a named phase; it falls back to AR_B at once.
    always_comb begin
        nxt = state;
        if (state == state_t'(3'd7)) nxt = AR_B;
        else if (adv)                nxt = succ(state, ped_pend);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= AR_B;
            timer    <= load(AR_B);
            ped_pend <= 1'b0;
            {ns_red, ns_yellow, ns_green,
             ew_red, ew_yellow, ew_green, walk} <= lamps(AR_B);
        end else begin
            state <= nxt;
            if (nxt != state)
                timer <= load(nxt);
            else if (!hold)
                timer <= timer - CNT_W'(1);
            // Entering WALK serves the request; a press on that edge is absorbed.
            if (nxt == WALK && state != WALK)
                ped_pend <= 1'b0;
            else if (ped_req && state != WALK)
                ped_pend <= 1'b1;
            {ns_red, ns_yellow, ns_green,
             ew_red, ew_yellow, ew_green, walk} <= lamps(nxt);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl: phase timing, pedestrian
// latching, hold stretching, mid-phase reset and a random soak.
module tb_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req;
    logic       hold;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       walk, ped_pend;
    logic [2:0] state_o;
    logic [6:0] lamp_v;

    int errors = 0;
    int checks = 0;

    intersection_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ped_req   (ped_req),
        .hold      (hold),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .walk      (walk),
        .ped_pend  (ped_pend),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    assign lamp_v = {ns_red, ns_yellow, ns_green,
                     ew_red, ew_yellow, ew_green, walk};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} per phase
    function automatic logic [6:0] exp_lamps(input int s);
        case (s)
            0:       exp_lamps = 7'b0011000;
            1:       exp_lamps = 7'b0101000;
            3:       exp_lamps = 7'b1000010;
            4:       exp_lamps = 7'b1000100;
            6:       exp_lamps = 7'b1001001;
            default: exp_lamps = 7'b1001000;
        endcase
    endfunction

    function automatic int dur(input int s);
        case (s)
            0, 3:    dur = 8;
            1, 4:    dur = 3;
            6:       dur = 6;
            default: dur = 1;
        endcase
    endfunction

    task automatic run_phase(input int st, input int n, input logic pend);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("state p%0d c%0d", st, i), 32'(state_o), 32'(st));
            chk($sformatf("lamps p%0d c%0d", st, i), 32'(lamp_v),
                32'(exp_lamps(st)));
            chk($sformatf("pend p%0d c%0d", st, i), 32'(ped_pend), 32'(pend));
            tick();
        end
    endtask

    // NS_G with a one-cycle press in its 5th cycle
    task automatic ns_g_press();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("state nsg_press c%0d", i), 32'(state_o), 32'd0);
            chk($sformatf("pend nsg_press c%0d", i), 32'(ped_pend),
                32'(i >= 5));
            if (i == 4) ped_req = 1'b1;
            tick();
            ped_req = 1'b0;
        end
    endtask

    task automatic full_period(input logic pend);
        run_phase(0, 8, pend);
        run_phase(1, 3, pend);
        run_phase(2, 1, pend);
        run_phase(3, 8, pend);
        run_phase(4, 3, pend);
        run_phase(5, 1, pend);
    endtask

    int   cnt;
    int   prev;
    logic seen;

    initial begin
        rst     = 1'b0;
        ped_req = 1'b0;
        hold    = 1'b0;
        repeat (3) tick();
        chk("rst state", 32'(state_o), 32'd5);
        chk("rst lamps", 32'(lamp_v), 32'(7'b1001000));
        chk("rst pend", 32'(ped_pend), 32'd0);
        rst = 1'b1;

        // Plain cycling: one all-red cycle, then two full periods
        run_phase(5, 1, 1'b0);
        full_period(1'b0);
        full_period(1'b0);

        // Single press served by one WALK
        ns_g_press();
        run_phase(1, 3, 1'b1);
        run_phase(2, 1, 1'b1);
        run_phase(3, 8, 1'b1);
        run_phase(4, 3, 1'b1);
        run_phase(5, 1, 1'b1);
        run_phase(6, 6, 1'b0);

        // Button held across WALK is ignored there
        ns_g_press();
        run_phase(1, 3, 1'b1);
        run_phase(2, 1, 1'b1);
        run_phase(3, 8, 1'b1);
        run_phase(4, 3, 1'b1);
        run_phase(5, 1, 1'b1);
        ped_req = 1'b1;
        run_phase(6, 6, 1'b0);
        ped_req = 1'b0;
        full_period(1'b0);
        run_phase(0, 1, 1'b0);
        run_phase(0, 7, 1'b0);

        // Hold over the final EW_G cycle stretches it to 18
        run_phase(1, 3, 1'b0);
        run_phase(2, 1, 1'b0);
        run_phase(3, 7, 1'b0);
        hold = 1'b1;
        run_phase(3, 10, 1'b0);
        hold = 1'b0;
        run_phase(3, 1, 1'b0);
        run_phase(4, 3, 1'b0);
        run_phase(5, 1, 1'b0);

        // Reset in the 2nd EW_Y cycle with a pending press
        ns_g_press();
        run_phase(1, 3, 1'b1);
        run_phase(2, 1, 1'b1);
        run_phase(3, 8, 1'b1);
        run_phase(4, 1, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst state", 32'(state_o), 32'd5);
        chk("midrst lamps", 32'(lamp_v), 32'(7'b1001000));
        chk("midrst pend", 32'(ped_pend), 32'd0);
        chk("midrst walk", 32'(walk), 32'd0);
        run_phase(5, 1, 1'b0);
        run_phase(0, 8, 1'b0);

        // Random soak: lamp invariants and hold-adjusted phase lengths
        cnt  = 0;
        prev = int'(state_o);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            ped_req = ($urandom_range(0, 7) == 0);
            hold    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk("soak ns onehot", 32'($onehot({ns_red, ns_yellow, ns_green})),
                32'd1);
            chk("soak ew onehot", 32'($onehot({ew_red, ew_yellow, ew_green})),
                32'd1);
            chk("soak conflict", 32'(!ns_red && !ew_red), 32'd0);
            if (int'(state_o) != prev) begin
                if (seen)
                    chk($sformatf("soak len p%0d", prev), 32'(cnt),
                        32'(dur(prev)));
                seen = 1'b1;
                cnt  = 0;
            end
            if (!hold) cnt++;
            prev = int'(state_o);
            tick();
        end
        ped_req = 1'b0;
        hold    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
